// File: rtl/sccb_arbiter_pkg.sv
// Shared FSM encodings, field widths and helpers for the two-port SCCB arbiter.
package sccb_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEF = 2;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ID_W        = 8;
    localparam int unsigned DLY_W       = 32;
    localparam int unsigned CNT_W       = DLY_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sccb_rr_pick.sv
// Two-way round-robin winner selection; prio names the requester favoured on a tie.
module sccb_rr_pick (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       any,
    output logic       win_idx
);

    // Winner decode: a lone requester wins, a tie goes to the favoured one
    always_comb begin
        any     = |req;
        win_idx = 1'b0;
        case (req)
            2'b11:   win_idx = prio;
            2'b10:   win_idx = 1'b1;
            2'b01:   win_idx = 1'b0;
            default: win_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/sccb_arbiter.sv
// Round-robin arbiter sharing one SCCB register engine between two requesters,
// with a per-transaction completion timeout.
module sccb_arbiter
    import sccb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = NUM_REQ_DEF,
    parameter int unsigned TIMEOUT_CNT = 32'd2_500_000
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_rd,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]         req_addr_mode,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wrdata,
    input  logic [NUM_REQ*ID_W-1:0]    req_device_id,
    input  logic [NUM_REQ*DLY_W-1:0]   req_dly,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       nack,
    output logic                       timeout,
    output logic [DATA_W-1:0]          rddata,
    output logic                       wrreg_req,
    output logic                       rdreg_req,
    output logic [ADDR_W-1:0]          addr,
    output logic                       addr_mode,
    output logic [DATA_W-1:0]          wrdata,
    output logic [ID_W-1:0]            device_id,
    output logic [DLY_W-1:0]           dly_cnt_max,
    input  logic [DATA_W-1:0]          eng_rddata,
    input  logic                       RW_Done,
    input  logic                       ack
);

    arb_state_t       state_r, state_s;
    logic             pick_any_s, pick_idx_s;
    logic             rr_ptr_r;
    logic             rd_r;
    logic [CNT_W-1:0] cnt_r, cnt_inc_s, limit_s;
    logic             hit_s;

    sccb_rr_pick u_rr_pick (
        .req     (req),
        .prio    (rr_ptr_r),
        .any     (pick_any_s),
        .win_idx (pick_idx_s)
    );

    // Timeout limit and saturating counter increment; 33 bits keep the sum exact
    always_comb begin
        limit_s = CNT_W'(TIMEOUT_CNT) + {1'b0, dly_cnt_max};
        if (cnt_r == {CNT_W{1'b1}}) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + 33'd1;
        end
        hit_s = (cnt_inc_s >= limit_s);
    end

    // FSM state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (RW_Done || hit_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Grant capture, engine strobes, completion status and the WAIT counter
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            grant       <= 2'b00;
            done        <= 2'b00;
            nack        <= 1'b0;
            timeout     <= 1'b0;
            rddata      <= 8'h00;
            wrreg_req   <= 1'b0;
            rdreg_req   <= 1'b0;
            addr        <= 16'h0000;
            addr_mode   <= 1'b0;
            wrdata      <= 8'h00;
            device_id   <= 8'h00;
            dly_cnt_max <= 32'h0000_0000;
            rd_r        <= 1'b0;
            rr_ptr_r    <= 1'b0;
            cnt_r       <= 33'h0_0000_0000;
        end else begin
            wrreg_req <= 1'b0;
            rdreg_req <= 1'b0;
            done      <= 2'b00;
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        grant       <= idx_to_onehot(pick_idx_s);
                        rr_ptr_r    <= ~pick_idx_s;
                        rd_r        <= req_rd[pick_idx_s];
                        addr_mode   <= req_addr_mode[pick_idx_s];
                        addr        <= pick_idx_s ? req_addr[31:16]      : req_addr[15:0];
                        wrdata      <= pick_idx_s ? req_wrdata[15:8]     : req_wrdata[7:0];
                        device_id   <= pick_idx_s ? req_device_id[15:8]  : req_device_id[7:0];
                        dly_cnt_max <= pick_idx_s ? req_dly[63:32]       : req_dly[31:0];
                    end
                end
                ST_ISSUE: begin
                    wrreg_req <= ~rd_r;
                    rdreg_req <= rd_r;
                    cnt_r     <= 33'h0_0000_0000;
                end
                ST_WAIT: begin
                    // A completion in the same cycle as the limit wins over the timeout
                    if (RW_Done) begin
                        done    <= grant;
                        nack    <= ack;
                        timeout <= 1'b0;
                        if (rd_r && !ack) begin
                            rddata <= eng_rddata;
                        end
                    end else if (hit_s) begin
                        done    <= grant;
                        nack    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_RESP: begin
                    grant <= 2'b00;
                end
                default: begin
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: doc/sccb_arbiter.md
SCCB_ARBITER -- requirements
Module: sccb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requester ports (fixed 2 in this revision).
REQ-002 Parameter TIMEOUT_CNT, default 2_500_000, Clk cycles allowed per transaction beyond the requester's dly_cnt_max before abort.
REQ-003 Clk  input  1  system clock; all logic is on the rising edge.
REQ-004 Rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  [1:0]  per-requester level request, held until done.
REQ-006 req_rd  input  [1:0]  per-requester direction: 1 = read, 0 = write.
REQ-007 req_addr  input  [31:0]  two 16-bit register addresses; requester i uses [16i+15:16i].
REQ-008 req_addr_mode  input  [1:0]  per-requester: 1 = 16-bit address, 0 = 8-bit address.
REQ-009 req_wrdata  input  [15:0]  two 8-bit write-data fields.
REQ-010 req_device_id  input  [15:0]  two 8-bit SCCB device IDs.
REQ-011 req_dly  input  [63:0]  two 32-bit post-transaction delay counts.
REQ-012 grant  output  [1:0]  one-hot; identifies the owner of the current transaction.
REQ-013 done  output  [1:0]  one-cycle pulse to the owner when its transaction ends.
REQ-014 nack  output  1  valid with done: 1 = slave NACK or timeout.
REQ-015 timeout  output  1  valid with done: 1 = the transaction was aborted by timeout.
REQ-016 rddata  output  8  read data, valid with done when the read succeeded.
REQ-017 Engine side: wrreg_req and rdreg_req (out 1 each), addr (out 16), addr_mode (out 1), wrdata (out 8), device_id (out 8), dly_cnt_max (out 32); eng_rddata (in 8), RW_Done (in 1), ack (in 1, 1 = NACK).

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: when any req bit is high, select a winner, register its fields onto the engine-side outputs and into grant, then go to ISSUE.
REQ-020 Arbitration SHALL be round-robin. When both requesters are high, the one not granted last wins. After reset, requester 0 wins.
REQ-021 ISSUE: assert wrreg_req (if req_rd = 0) or rdreg_req (if req_rd = 1) for exactly one cycle, then go to WAIT.
REQ-022 WAIT: on RW_Done, capture ack and eng_rddata and go to RESP.
REQ-023 WAIT: a counter runs from 0. When it reaches TIMEOUT_CNT + dly_cnt_max, go to RESP with nack = 1 and timeout = 1.
REQ-024 The WAIT counter SHALL be 33 bits wide and saturate, so the compare never wraps.
REQ-025 RESP: pulse done[owner] for one cycle, clear grant, return to IDLE. A new grant occurs no earlier than the next cycle.
REQ-026 Latency from a granted request to the engine strobe is 2 cycles (IDLE→ISSUE→strobe).
REQ-027 Engine-side fields SHALL stay stable from ISSUE until the state leaves RESP.
REQ-028 A request dropped mid-transaction is ignored. The transaction completes and done still pulses.
REQ-029 RW_Done received outside WAIT SHALL be ignored.
REQ-030 If RW_Done and the timeout limit coincide, RW_Done takes precedence (timeout = 0).
REQ-031 At most one grant bit and at most one done bit SHALL be high at any time.
REQ-032 rddata SHALL hold its last captured value until the next successful read.

Reset
REQ-033 On Rst_n low, asynchronously return to IDLE and clear all of the following to 0:
- grant, done, nack, timeout, rddata
- wrreg_req, rdreg_req
- addr, wrdata, device_id, dly_cnt_max, addr_mode
- the WAIT counter
- the last-grant pointer (so requester 0 wins first)
REQ-034 A reset during WAIT SHALL NOT produce a done pulse. Requesters must re-request after reset release.

Structure
REQ-035 The shared package SHALL hold:
- the FSM state encodings (2 bits)
- the NUM_REQ default
- the field widths: address 16, data 8, ID 8, delay 32
REQ-036 One sub-module, sccb_rr_pick, SHALL implement the 2-way round-robin winner selection combinationally.
REQ-037 The existing camera_init sequencer SHALL connect as requester 0. Runtime register access (exposure and gain tweaks) SHALL connect as requester 1.

Verification
REQ-038 Single write: req = 01, addr 0x3008, data 0x82, ID 0x78; the engine model raises RW_Done with ack = 0 after 100 cycles → one wrreg_req pulse, then done = 01 with nack = 0.
REQ-039 Contention: req = 11 held for three transactions → grants in order 01, 10, 01, and never two simultaneous grants.
REQ-040 Read: requester 1, read of 0x300A; the model returns 0x56 → rdreg_req pulse, then done = 10 with rddata = 0x56.
REQ-041 Timeout: TIMEOUT_CNT = 50, dly = 10, model silent → done at 60 WAIT cycles with nack = 1 and timeout = 1, and the next request is then served.
REQ-042 Simultaneity and reset:
- RW_Done lands in the cycle the limit is hit → timeout = 0.
- Rst_n is pulsed low mid-WAIT → no done pulse, all outputs 0, and the next grant goes to requester 0.
